bram_rmw_port: RTL

//  Request front-end for one port of the 1024x16 dual-port BRAM wrapper. That wrapper ignores its
//  per-bit write mask, so this block implements it by read-modify-write on the port.

---
 rtl/bram_rmw_pkg.sv | 32 +++
 rtl/bram_rmw_port.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bram_rmw_pkg.sv
// Shared types for the BRAM read-modify-write port: FSM state encoding,
// default geometry and the write-mask classifier.
package bram_rmw_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MASK_NONE = 2'd0,
    MASK_FULL = 2'd1,
    MASK_PART = 2'd2
  } mask_class_t;

  // Callers pass the AND- and OR-reduction of the mask so this stays width-agnostic.
  function automatic mask_class_t classify_mask(input logic all_ones, input logic any_ones);
    mask_class_t cls;
    if (all_ones)
      cls = MASK_FULL;
    else if (!any_ones)
      cls = MASK_NONE;
    else
      cls = MASK_PART;
    return cls;
  endfunction

endpackage

// File: rtl/bram_rmw_port.sv
// One-port request front-end for a dual-port BRAM whose write mask is ignored:
// partial writes become read-then-merge, with an optional post-reset clear sweep.
//
// state    | meaning
// ST_CLEAR | writing CLEAR_VALUE to address cnt, requests blocked
// ST_IDLE  | accepting reads, full writes, empty writes, starting partial writes
// ST_MERGE | old word on MEM_Q, writing merged word to latched address
module bram_rmw_port
  import bram_rmw_pkg::*;
#(
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                DATA_W         = DEF_DATA_W,
  parameter bit                CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [DATA_W-1:0] REQ_WMASK,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              CLEAR_DONE,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [DATA_W-1:0] MEM_D,
  output logic              MEM_WE,
  output logic              MEM_CE,
  input  logic [DATA_W-1:0] MEM_Q
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] lat_mask;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              clear_done_q;

  logic              accept;
  mask_class_t       req_class;

  logic              mem_ce_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_a_c;
  logic [DATA_W-1:0] mem_d_c;

  assign accept    = REQ_VALID && ready_q;
  assign req_class = classify_mask(&REQ_WMASK, |REQ_WMASK);

  // Gated by RSTN so the port is quiet while reset is held, even in ST_CLEAR.
  always_comb begin
    mem_ce_c = 1'b0;
    mem_we_c = 1'b0;
    mem_a_c  = '0;
    mem_d_c  = '0;
    if (RSTN) begin
      case (state)
        ST_CLEAR: begin
          mem_ce_c = 1'b1;
          mem_we_c = 1'b1;
          mem_a_c  = cnt[ADDR_W-1:0];
          mem_d_c  = CLEAR_VALUE;
        end
        ST_IDLE: begin
          if (accept) begin
            mem_a_c = REQ_ADDR;
            if (!REQ_WE) begin
              mem_ce_c = 1'b1;
            end else begin
              case (req_class)
                MASK_FULL: begin
                  mem_ce_c = 1'b1;
                  mem_we_c = 1'b1;
                  mem_d_c  = REQ_WDATA;
                end
                MASK_PART: mem_ce_c = 1'b1;
                default:   mem_ce_c = 1'b0;
              endcase
            end
          end
        end
        ST_MERGE: begin
          mem_ce_c = 1'b1;
          mem_we_c = 1'b1;
          mem_a_c  = lat_addr;
          mem_d_c  = (MEM_Q & ~lat_mask) | (lat_wdata & lat_mask);
        end
        default: mem_ce_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_mask     <= '0;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      clear_done_q <= ~CLEAR_ON_RESET;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state        <= ST_IDLE;
            clear_done_q <= 1'b1;
            ready_q      <= 1'b1;
          end
        end
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (!REQ_WE) begin
              rsp_valid_q <= 1'b1;
            end else if (req_class == MASK_PART) begin
              lat_addr  <= REQ_ADDR;
              lat_wdata <= REQ_WDATA;
              lat_mask  <= REQ_WMASK;
              state     <= ST_MERGE;
              ready_q   <= 1'b0;
            end
          end
        end
        ST_MERGE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY  = ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RDATA  = MEM_Q;
  assign CLEAR_DONE = clear_done_q;
  assign MEM_CE     = mem_ce_c;
  assign MEM_WE     = mem_we_c;
  assign MEM_A      = mem_a_c;
  assign MEM_D      = mem_d_c;

endmodule
